button_event: RTL and testbench

- Consumer end of the debounced push-button level: takes one clean, already-synchronised level from the 11-bit debouncer and decodes it into single-cycle event strobes for the game/control FSMs.
- Strobes: press, release, long-press and auto-repeat, plus a "held long" level.
- Sits between each debouncer output and the top-level control logic. One instance per button.

---
 rtl/button_event.sv | 122 ++++++++++++
 tb/tb_button_event.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/button_event.sv
// Decodes one debounced, synchronised button level into press/release/long/repeat
// strobes and a "held long" level. One instance per button.
module button_event #(
  parameter int LONG_CYCLES   = 8,
  parameter int REPEAT_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic in_i,
  output logic press_o,
  output logic release_o,
  output logic long_o,
  output logic repeat_o,
  output logic held_o
);

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    LONG_HOLD
  } state_e;

  localparam logic [CNT_W-1:0] LONG_C = CNT_W'(LONG_CYCLES);
  localparam logic [CNT_W-1:0] REP_C  = CNT_W'(REPEAT_CYCLES);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             prev_q;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             long_q, long_d;
  logic             repeat_q, repeat_d;
  logic             held_q, held_d;

  logic rise, fall;
  assign rise = in_i & ~prev_q;
  assign fall = ~in_i & prev_q;

  // Reset forces IDLE silently: a hold interrupted by rst never yields a release.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      prev_q    <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      prev_q    <= in_i;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
      held_q    <= held_d;
    end
  end

  // A fall is tested before the terminal counts so release wins over long/repeat.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    held_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          press_d = 1'b1;
          cnt_d   = ONE_C;
          state_d = PRESSED;
        end
      end
      PRESSED: begin
        if (fall) begin
          release_d = 1'b1;
          cnt_d     = '0;
          state_d   = IDLE;
        end else if (cnt_q == LONG_C) begin
          long_d  = 1'b1;
          held_d  = 1'b1;
          cnt_d   = ONE_C;
          state_d = LONG_HOLD;
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end
      LONG_HOLD: begin
        held_d = 1'b1;
        if (fall) begin
          release_d = 1'b1;
          held_d    = 1'b0;
          cnt_d     = '0;
          state_d   = IDLE;
        end else if (cnt_q == REP_C) begin
          repeat_d = 1'b1;
          cnt_d    = ONE_C;
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;
  assign repeat_o  = repeat_q;
  assign held_o    = held_q;

endmodule

// File: tb/tb_button_event.sv
// Randomised and directed bench for button_event, checked against a model that
// tracks only how many edges the button has been sampled high.
module tb_button_event;

  localparam int L = 8;
  localparam int R = 4;

  logic clk;
  logic rst;
  logic inSig;
  logic press, release_s, longS, repeatS, held;

  int assertCount = 0;
  int failCount   = 0;

  // Reference model state
  logic mPrev;
  int   mRun;
  logic expPress, expRelease, expLong, expRepeat, expHeld;
  logic expectPress;

  button_event #(
    .LONG_CYCLES  (L),
    .REPEAT_CYCLES(R),
    .CNT_W        (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_i     (inSig),
    .press_o  (press),
    .release_o(release_s),
    .long_o   (longS),
    .repeat_o (repeatS),
    .held_o   (held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic observed, input logic expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", tag, observed, expected, $time);
    end
  endtask

  // mRun counts edges since the one that sampled the rise.
  task automatic modelStep(input logic inVal, input logic rstVal);
    expPress   = 1'b0;
    expRelease = 1'b0;
    expLong    = 1'b0;
    expRepeat  = 1'b0;
    expHeld    = 1'b0;
    if (rstVal) begin
      mPrev = 1'b0;
      mRun  = 0;
    end else begin
      if (inVal && !mPrev) begin
        expPress = 1'b1;
        mRun     = 0;
      end else if (inVal && mPrev) begin
        mRun++;
        expLong   = (mRun == L);
        expRepeat = (mRun > L) && (((mRun - L) % R) == 0);
        expHeld   = (mRun >= L);
      end else if (!inVal && mPrev) begin
        expRelease = 1'b1;
      end
      mPrev = inVal;
    end
  endtask

  task automatic compareAll(input logic rstVal);
    checkOutput("press", press, expPress);
    checkOutput("release", release_s, expRelease);
    checkOutput("long", longS, expLong);
    checkOutput("repeat", repeatS, expRepeat);
    checkOutput("held", held, expHeld);
    if (press) begin
      checkOutput("altPress", expectPress, 1'b1);
      expectPress = 1'b0;
    end
    if (release_s) begin
      checkOutput("altRelease", expectPress, 1'b0);
      expectPress = 1'b1;
    end
    if (rstVal) expectPress = 1'b1;
  endtask

  task automatic applyStimulus(input logic inVal, input logic rstVal, input int n);
    for (int i = 0; i < n; i++) begin
      inSig = inVal;
      rst   = rstVal;
      @(posedge clk);
      modelStep(inVal, rstVal);
      @(negedge clk);
      compareAll(rstVal);
    end
  endtask

  initial begin
    logic lvl;
    mPrev       = 1'b0;
    mRun        = 0;
    expectPress = 1'b1;
    inSig       = 1'b0;
    rst         = 1'b1;

    applyStimulus(1'b0, 1'b1, 3);
    // Long hold with repeats, then release
    applyStimulus(1'b1, 1'b0, 20);
    applyStimulus(1'b0, 1'b0, 5);
    // Short press
    applyStimulus(1'b1, 1'b0, 3);
    applyStimulus(1'b0, 1'b0, 4);
    // Fall exactly at the long terminal edge
    applyStimulus(1'b1, 1'b0, L);
    applyStimulus(1'b0, 1'b0, 4);
    // Button held through reset
    applyStimulus(1'b1, 1'b1, 3);
    applyStimulus(1'b1, 1'b0, 5);
    applyStimulus(1'b0, 1'b0, 3);
    // Reset mid LONG_HOLD, button still down
    applyStimulus(1'b1, 1'b0, 10);
    applyStimulus(1'b1, 1'b1, 1);
    applyStimulus(1'b1, 1'b0, 14);
    applyStimulus(1'b0, 1'b0, 3);
    // Toggling every cycle
    for (int i = 0; i < 10; i++) applyStimulus((i % 2) == 0, 1'b0, 1);
    applyStimulus(1'b0, 1'b0, 2);

    lvl = 1'b0;
    for (int s = 0; s < 200; s++) begin
      if ($urandom_range(0, 19) == 0) applyStimulus(lvl, 1'b1, $urandom_range(1, 3));
      lvl = ~lvl;
      applyStimulus(lvl, 1'b0, $urandom_range(1, 25));
    end
    applyStimulus(1'b0, 1'b0, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
